// File: rtl/serial_frame_ctrl.sv
// Decodes start/port/length frame headers from a raw serial line and gates payload bits to the port demux.
// Payload bits reach SerOut combinationally while data_valid=1; a one-cycle done pulse follows the last one.
module serial_frame_ctrl #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SerIn,
  output logic [PORT_W-1:0] portnum,
  output logic              SerOut,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);
  localparam int MAXW  = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int CNT_W = $clog2(MAXW + 1);

  typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PORT_W-1:0] port_sr_q, port_sr_d, portnum_q, portnum_d;
  logic [LEN_W-1:0]  len_sr_q, len_sr_d, rem_q, rem_d;
  logic              busy_q, dv_q, done_q;
  logic [PORT_W:0]   port_full;
  logic [LEN_W:0]    len_full;

  // Header fields assembled MSB first, including the bit currently on the line.
  assign port_full = {port_sr_q, SerIn};
  assign len_full  = {len_sr_q, SerIn};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_sr_d = port_sr_q;
    portnum_d = portnum_q;
    len_sr_d  = len_sr_q;
    rem_d     = rem_q;
    case (state_q)
      IDLE: begin
        if (!SerIn) begin
          state_d = PORT;
          cnt_d   = '0;
        end
      end
      PORT: begin
        port_sr_d = port_full[PORT_W-1:0];
        if (cnt_q == CNT_W'(PORT_W - 1)) begin
          portnum_d = port_full[PORT_W-1:0];
          cnt_d     = '0;
          state_d   = LEN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LEN: begin
        len_sr_d = len_full[LEN_W-1:0];
        if (cnt_q == CNT_W'(LEN_W - 1)) begin
          cnt_d = '0;
          if (len_full[LEN_W-1:0] == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = len_full[LEN_W-1:0];
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_sr_q <= '0;
      portnum_q <= '0;
      len_sr_q  <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_sr_q <= port_sr_d;
      portnum_q <= portnum_d;
      len_sr_q  <= len_sr_d;
      rem_q     <= rem_d;
      busy_q    <= (state_d != IDLE);
      dv_q      <= (state_d == DATA);
      done_q    <= (state_d == DONE);
    end
  end

  assign portnum    = portnum_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign SerOut     = SerIn & dv_q;

endmodule
